serial_subtractor_16: RTL and testbench

SERIAL_SUBTRACTOR_16 -- requirements
Module: serial_subtractor_16

---
 rtl/serial_subtractor_16.sv | 100 ++++++++++
 tb/tb_serial_subtractor_16.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16.sv
// Bit-serial N-bit subtractor: a - b - bin, one bit per cycle LSB first.
// valid/ready on both sides; results are held in DONE until accepted.

module serial_subtractor_16 #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        st_idle,
        st_run,
        st_done
    } state_t;

    state_t          state_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    dsh_q;
    logic            br_q;
    logic [CW-1:0]   cnt_q;

    logic            diff;
    logic            br_next;
    logic [N-1:0]    dsh_next;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    always_comb begin
        diff     = a_q[0] ^ b_q[0] ^ br_q;
        br_next  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
        dsh_next = {diff, dsh_q[N-1:1]};
    end

    assign in_ready  = (state_q == st_idle);
    assign out_valid = (state_q == st_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= st_idle;
            a_q     <= '0;
            b_q     <= '0;
            dsh_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d       <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            unique case (state_q)
                st_idle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        dsh_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= st_run;
                    end
                end
                st_run: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    dsh_q <= dsh_next;
                    br_q  <= br_next;
                    if (cnt_q == CW'(N - 1)) begin
                        // Last cell: the shifter LSBs now hold the operand sign bits.
                        d       <= dsh_next;
                        bout    <= br_next;
                        ovf     <= (a_q[0] != b_q[0]) && (diff != a_q[0]);
                        state_q <= st_done;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                st_done: begin
                    if (out_ready) begin
                        state_q <= st_idle;
                    end
                end
                default: begin
                    state_q <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_16.sv
// Scoreboard bench for serial_subtractor_16: directed vectors, backpressure,
// mid-RUN reset and random back-to-back traffic against an integer model.

module tb_serial_subtractor_16;

    localparam int unsigned N = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  d;
    logic          bout;
    logic          ovf;

    serial_subtractor_16 #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [N-1:0] d;
        logic         bout;
        logic         ovf;
        int unsigned  acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        head;
    int unsigned cyc;
    int unsigned n_vec;
    int unsigned n_miss;
    bit          seen;
    int unsigned rdy_mode;   // 0: always ready, 1: random stalls, 2: hold low

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: widened unsigned difference and signed range test.
    task automatic model(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rbin,
                         output logic [N-1:0] rd, output logic rbo, output logic rov);
        logic [N:0] wide;
        int         sr;
        wide = {1'b0, ra} - {1'b0, rb} - {{N{1'b0}}, rbin};
        rd   = wide[N-1:0];
        rbo  = wide[N];
        sr   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
        rov  = (sr > 32767) || (sr < -32768);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                head = sb[0];
                if (!seen) begin
                    chk("latency", cyc - head.acc, N);
                    seen = 1'b1;
                end
                chk("d", 32'(d), 32'(head.d));
                chk("bout", 32'(bout), 32'(head.bout));
                chk("ovf", 32'(ovf), 32'(head.ovf));
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vbin,
                        input logic [N-1:0] ed, input logic eb, input logic eo);
        exp_t        e;
        int unsigned t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        bin      = vbin;
        @(posedge clk);
        #1;
        e.d    = ed;
        e.bout = eb;
        e.ovf  = eo;
        e.acc  = cyc;
        sb.push_back(e);
        // Scramble inputs during RUN; they must not matter.
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        bin      = 1'($urandom);
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rd;
        logic         rbo;
        logic         rov;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rbin;
        int unsigned  t;

        cyc       = 0;
        n_vec     = 0;
        n_miss    = 0;
        seen      = 1'b0;
        rdy_mode  = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        rst_n     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, hand-computed.
        send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain();
        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        drain();
        send(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        drain();
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        drain();
        send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        drain();
        send(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        drain();

        // Backpressure: stall in DONE while wiggling inputs.
        @(negedge clk);
        rdy_mode = 2;
        send(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a        = N'($urandom);
            b        = N'($urandom);
            bin      = ~bin;
        end
        in_valid = 1'b0;
        @(negedge clk);
        rdy_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid), 32'd0);
        chk("bp_sb_empty", sb.size(), 0);

        // Asynchronous reset after 7 RUN cycles abandons the transaction.
        send(16'h0123, 16'h0045, 1'b0, 16'h00DE, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_d", 32'(d), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_no_result", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
        drain();

        // Random back-to-back traffic with random consumer stalls.
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            ra   = N'($urandom);
            rb   = N'($urandom);
            rbin = 1'($urandom);
            if (i < 4) begin
                ra = (i[0]) ? 16'hFFFF : 16'h0000;
                rb = (i[1]) ? 16'hFFFF : 16'h8000;
            end
            model(ra, rb, rbin, rd, rbo, rov);
            send(ra, rb, rbin, rd, rbo, rov);
        end
        drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
